// File: rtl/mul_div_iter_if.sv
// Request/result bundle for the HI/LO multiply-divide unit.
// master drives the request strobe and operands; slave returns status and HI/LO.
interface mul_div_iter_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [3:0]       Op;
    logic [WIDTH-1:0] RData1;
    logic [WIDTH-1:0] RData2;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] HI_Outcome;
    logic [WIDTH-1:0] LO_Outcome;

    modport master (
        output Start, Op, RData1, RData2,
        input  Busy, Done, HI_Outcome, LO_Outcome
    );

    modport slave (
        input  Start, Op, RData1, RData2,
        output Busy, Done, HI_Outcome, LO_Outcome
    );
endinterface

// File: rtl/mul_div_iter.sv
// HI/LO multiply (fixed MUL_LATENCY) and radix-2 restoring divide (WIDTH+1 cycles); Start ignored while Busy.
// Accumulating MADD/MADDU/MSUB/MSUBU ops exist only when MUL_DIV_MADD_EN is defined.
module mul_div_iter #(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 5
) (
    input  logic          clk,
    input  logic          reset,
    mul_div_iter_if.slave bus
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    localparam int CNT_MAX = (MUL_LATENCY > WIDTH) ? MUL_LATENCY : WIDTH;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] LAT_C  = CW'(MUL_LATENCY);
    localparam logic [CW-1:0] LAST_C = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     cnt;
    logic [3:0]        op_q;
    logic [WIDTH-1:0]  a_q, b_q, rem;
    logic [WIDTH-1:0]  hi, lo;
    logic              done;
    logic              q_neg, r_neg;

    logic              go, mul_req, div_req;
    logic              sgn_a, sgn_b;
    logic [WIDTH-1:0]  mag_a, mag_b;
    logic              signed_mul;
    logic [2*WIDTH-1:0] ext_a, ext_b, product, mul_result;
    logic [WIDTH:0]    shifted;
    logic              ge;
    logic [WIDTH-1:0]  diff, rem_nx;

    always_comb begin
        mul_req = 1'b0;
        div_req = 1'b0;
        case (bus.Op)
            OP_MULT, OP_MULTU: mul_req = 1'b1;
`ifdef MUL_DIV_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: mul_req = 1'b1;
`endif
            OP_DIV, OP_DIVU: div_req = 1'b1;
            default: ;
        endcase
    end

    assign go    = bus.Start && (state == IDLE);
    assign sgn_a = (bus.Op == OP_DIV) && bus.RData1[WIDTH-1];
    assign sgn_b = (bus.Op == OP_DIV) && bus.RData2[WIDTH-1];
    assign mag_a = sgn_a ? -bus.RData1 : bus.RData1;
    assign mag_b = sgn_b ? -bus.RData2 : bus.RData2;

    // Operands are sign- or zero-extended to 2*WIDTH so one multiplier serves both signednesses.
    assign signed_mul = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
    assign ext_a   = signed_mul ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    assign ext_b   = signed_mul ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    assign product = ext_a * ext_b;

    always_comb begin
`ifdef MUL_DIV_MADD_EN
        case (op_q)
            OP_MADD, OP_MADDU: mul_result = {hi, lo} + product;
            OP_MSUB, OP_MSUBU: mul_result = {hi, lo} - product;
            default:           mul_result = product;
        endcase
`else
        mul_result = product;
`endif
    end

    // One restoring step: a_q shifts dividend bits out and quotient bits in.
    assign shifted = {rem, a_q[WIDTH-1]};
    assign ge      = shifted >= {1'b0, b_q};
    assign diff    = shifted[WIDTH-1:0] - b_q;
    assign rem_nx  = ge ? diff : shifted[WIDTH-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (go && mul_req)      state_nx = MUL;
                else if (go && div_req) state_nx = DIV;
            end
            MUL:     if (cnt == LAT_C)  state_nx = IDLE;
            DIV:     if (cnt == LAST_C) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            rem   <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (go && mul_req) begin
                        op_q <= bus.Op;
                        a_q  <= bus.RData1;
                        b_q  <= bus.RData2;
                        cnt  <= CW'(1);
                    end else if (go && div_req) begin
                        op_q  <= bus.Op;
                        a_q   <= mag_a;
                        b_q   <= mag_b;
                        rem   <= '0;
                        cnt   <= '0;
                        q_neg <= sgn_a ^ sgn_b;
                        r_neg <= sgn_a;
                    end else if (go && bus.Op == OP_MTHI) begin
                        hi <= bus.RData1;
                    end else if (go && bus.Op == OP_MTLO) begin
                        lo <= bus.RData2;
                    end
                end
                MUL: begin
                    if (cnt == LAT_C) begin
                        {hi, lo} <= mul_result;
                        done     <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DIV: begin
                    rem <= rem_nx;
                    a_q <= {a_q[WIDTH-2:0], ge};
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    // A zero divisor leaves HI/LO alone but still signals completion.
                    if (b_q != '0) begin
                        hi <= r_neg ? -rem : rem;
                        lo <= q_neg ? -a_q : a_q;
                    end
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.Busy       = (state != IDLE);
    assign bus.Done       = done;
    assign bus.HI_Outcome = hi;
    assign bus.LO_Outcome = lo;
endmodule

// File: tb/tb_mul_div_iter.sv
// Directed plus random ops on mul_div_iter, compared against a 64-bit arithmetic model of HI/LO.
// Build with MUL_DIV_MADD_EN defined to cover the accumulating ops.
module tb_mul_div_iter;
    localparam int W   = 32;
    localparam int LAT = 5;

`ifdef MUL_DIV_MADD_EN
    localparam bit MADD_ON = 1'b1;
`else
    localparam bit MADD_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mul_div_iter_if #(.WIDTH(W)) bus ();

    mul_div_iter #(.WIDTH(W), .MUL_LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_hi, ref_lo;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_mc(input logic [3:0] op);
        return (op >= 4'd1 && op <= 4'd4) || (MADD_ON && op >= 4'd7 && op <= 4'd10);
    endfunction

    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] acc);
        logic signed [63:0] sa, sb;
        logic [63:0]        ua, ub;
        longint             q, r;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            4'd1: return sa * sb;
            4'd2: return ua * ub;
            4'd3: begin
                if (b == 0) return acc;
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            4'd4: begin
                if (b == 0) return acc;
                return {a % b, a / b};
            end
            4'd5: return {a, acc[31:0]};
            4'd6: return {acc[63:32], b};
            4'd7:  return MADD_ON ? acc + sa * sb : acc;
            4'd8:  return MADD_ON ? acc + ua * ub : acc;
            4'd9:  return MADD_ON ? acc - sa * sb : acc;
            4'd10: return MADD_ON ? acc - ua * ub : acc;
            default: return acc;
        endcase
    endfunction

    // Called at a falling edge; returns at the falling edge where the result is visible.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit inject);
        logic [63:0] exp;
        int          n;
        exp = model(op, a, b, {ref_hi, ref_lo});
        bus.Start  = 1'b1;
        bus.Op     = op;
        bus.RData1 = a;
        bus.RData2 = b;
        @(posedge clk);
        @(negedge clk);
        bus.Start  = 1'b0;
        bus.Op     = 4'($urandom);
        bus.RData1 = $urandom;
        bus.RData2 = $urandom;
        if (is_mc(op)) begin
            n = 0;
            while (bus.Busy === 1'b1 && n < 100) begin
                n++;
                check("done_while_busy", bus.Done, 0);
                check("hilo_hold", {bus.HI_Outcome, bus.LO_Outcome}, {ref_hi, ref_lo});
                if (inject && n == 3) begin
                    bus.Start = 1'b1;
                    bus.Op    = 4'd1;
                end
                if (inject && n == 4) bus.Start = 1'b0;
                @(negedge clk);
            end
            check("busy_cycles", n, (op <= 4'd2 || op >= 4'd7) ? LAT : W + 1);
            check("done_pulse", bus.Done, 1);
        end else begin
            check("no_busy", bus.Busy, 0);
            check("no_done", bus.Done, 0);
        end
        {ref_hi, ref_lo} = exp;
        check("hi", bus.HI_Outcome, ref_hi);
        check("lo", bus.LO_Outcome, ref_lo);
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;
        reset      = 1'b1;
        bus.Start  = 1'b0;
        bus.Op     = 4'd0;
        bus.RData1 = '0;
        bus.RData2 = '0;
        ref_hi     = '0;
        ref_lo     = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", bus.Busy, 0);
        check("rst_done", bus.Done, 0);
        check("rst_hi", bus.HI_Outcome, 0);
        check("rst_lo", bus.LO_Outcome, 0);
        reset = 1'b0;
        @(negedge clk);

        issue(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check("mult_hi", bus.HI_Outcome, 32'hFFFF_FFFF);
        check("mult_lo", bus.LO_Outcome, 32'hFFFF_FFFA);
        issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("multu_hi", bus.HI_Outcome, 32'hFFFF_FFFE);
        check("multu_lo", bus.LO_Outcome, 32'h0000_0001);
        issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_lo", bus.LO_Outcome, 32'hFFFF_FFFD);
        check("div_hi", bus.HI_Outcome, 32'hFFFF_FFFF);
        issue(4'd4, 32'd7, 32'd0, 1'b0);
        check("div0_hi", bus.HI_Outcome, 32'hFFFF_FFFF);
        check("div0_lo", bus.LO_Outcome, 32'hFFFF_FFFD);
        issue(4'd5, 32'h1234_5678, $urandom, 1'b0);
        check("mthi", bus.HI_Outcome, 32'h1234_5678);
        issue(4'd3, $urandom, $urandom_range(1, 1000), 1'b1);
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("ovf_lo", bus.LO_Outcome, 32'h8000_0000);
        check("ovf_hi", bus.HI_Outcome, 32'h0000_0000);
        issue(4'd0, $urandom, $urandom, 1'b0);
        issue(4'd11, $urandom, $urandom, 1'b0);

        issue(4'd5, 32'd0, $urandom, 1'b0);
        issue(4'd6, $urandom, 32'hFFFF_FFFF, 1'b0);
        issue(4'd8, 32'd1, 32'd1, 1'b0);
        if (MADD_ON) begin
            check("maddu_hi", bus.HI_Outcome, 32'd1);
            check("maddu_lo", bus.LO_Outcome, 32'd0);
        end else begin
            check("maddu_off_hi", bus.HI_Outcome, 32'd0);
            check("maddu_off_lo", bus.LO_Outcome, 32'hFFFF_FFFF);
        end

        for (int i = 0; i < 30; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 :
                 ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 255)) : $urandom;
            issue(op, a, b, 1'b0);
        end

        bus.Start  = 1'b1;
        bus.Op     = 4'd3;
        bus.RData1 = $urandom;
        bus.RData2 = $urandom;
        @(posedge clk);
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_div_busy", bus.Busy, 1);
        reset = 1'b1;
        #1;
        check("abort_busy", bus.Busy, 0);
        check("abort_hi", bus.HI_Outcome, 0);
        check("abort_lo", bus.LO_Outcome, 0);
        check("abort_done", bus.Done, 0);
        ref_hi = '0;
        ref_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        issue(4'd2, $urandom, $urandom, 1'b0);

        @(negedge clk);
        check("done_falls", bus.Done, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul_div_iter.md
Name: mul_div_iter

Overview:
- Parametrised successor to the pipeline's HI/LO multiply/divide unit; sits beside the EX-stage ALU.
- Operands are captured at a Start handshake. Multiplies complete after a configurable fixed latency; divides use a true iterative radix-2 restoring divider, one quotient bit per cycle.
- Owns the HI/LO architectural registers. The hazard unit stalls the pipeline on Busy.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits (even, >=4).
- MUL_LATENCY, 5, cycles from Start acceptance to HI/LO update for multiply ops (>=1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- Start  input  1  request strobe; qualifies Op, RData1, RData2.
- Op  input  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU, 11-15 reserved.
- RData1  input  WIDTH  rs operand: dividend / multiplicand / MTHI source.
- RData2  input  WIDTH  rt operand: divisor / multiplier / MTLO source.
- Busy  output  1  operation in flight; new Start ignored.
- Done  output  1  one-cycle pulse after HI/LO update of a multi-cycle op.
- HI_Outcome  output  WIDTH  current HI register.
- LO_Outcome  output  WIDTH  current LO register.

Behaviour:
- Reset: HI=0, LO=0, Busy=0, Done=0, counter=0, FSM=IDLE. Aborts any operation immediately; no partial HI/LO write.
- Acceptance edge E0: Start=1, Busy=0, Op in 1-10 (7-10 only if the macro is defined). Operands and Op are latched at E0; later input changes have no effect.
- Start when Busy=1, or with Op 0/reserved: ignored, no state change. Start is not queued.
- MTHI/MTLO: single cycle, no Busy. HI<=RData1 (MTHI) or LO<=RData2 (MTLO) at E0. No Done pulse.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE->MUL on multiply accept.
  - IDLE->DIV on divide accept.
  - MUL->IDLE when the counter reaches MUL_LATENCY.
  - DIV->FIX after WIDTH iterations.
  - FIX->IDLE after one cycle.
- Multiply:
  - {HI,LO} <= 2*WIDTH-bit product at edge E0+MUL_LATENCY.
  - Busy=1 from E0 until that edge.
  - MULT is signed x signed; MULTU is zero-extended.
- Divide:
  - Operands are converted to magnitudes at E0.
  - DIV state performs WIDTH shift/subtract steps, one per edge.
  - FIX applies signs: quotient negated if operand signs differ; remainder takes the dividend's sign.
  - HI=remainder and LO=quotient are written at E0+WIDTH+1; Busy then falls.
- Divide by zero: runs full latency, HI/LO unchanged, Done still pulses.
- Signed DIV of most-negative by -1: LO=most-negative, HI=0, no trap.
- Done: registered. High the cycle after the HI/LO-writing edge of MUL/DIV/MADD-family ops, and only then.
- Back-to-back: a new Start is accepted in the same cycle Done=1, since Busy is already 0.
- HI_Outcome/LO_Outcome change only at E0 for MTHI/MTLO, or at a completion edge.

Optional Feature:
- Macro MUL_DIV_MADD_EN.
- Defined:
  - Ops 7-10 use the multiply path and latency.
  - Completion writes {HI,LO} <= {HI,LO} +/- product, using HI/LO as sampled at the completion edge (not at E0), modulo 2^(2*WIDTH).
  - MADD/MSUB form a signed product; MADDU/MSUBU an unsigned product.
- Undefined: ops 7-10 are treated as reserved and ignored. No accumulator adder is synthesised.

Test Plan:
- Reset, then MULT with RData1=0xFFFFFFFE (-2), RData2=3 -> Busy high 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA; Done pulses once.
- MULTU with 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 at E0+5.
- DIV with -7 / 2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1) at E0+33. Then DIVU with 7 / 0 -> HI/LO unchanged, Done pulses at E0+33.
- MTHI with 0x12345678 -> HI updated next edge, Busy stays 0. Start of MULT during a DIV in progress -> ignored; DIV result intact.
- Assert reset at cycle 10 of a DIV -> Busy=0, HI=LO=0 immediately; Start on the cycle after reset release is accepted.
- With MUL_DIV_MADD_EN: HI=0, LO=0xFFFFFFFF, then MADDU 1 x 1 -> HI=1, LO=0. Without the macro: same Op -> ignored, Busy stays 0.
